envelope_follower: RTL and testbench



---
 rtl/envelope_follower_pkg.sv | 14 +
 rtl/envelope_follower_if.sv | 23 ++
 rtl/envelope_follower_rate_stepper.sv | 29 ++
 rtl/envelope_follower.sv | 142 ++++++++++++++
 tb/tb_envelope_follower.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/envelope_follower_pkg.sv
// Shared audio definitions: default sample width, gate FSM encoding
// and the rate-accumulator width used by the envelope generator too.
package envelope_follower_pkg;

    localparam int SAMPLE_BITS_DEF = 16;

    // 8-bit fractional accumulator plus carry bit
    localparam int ACC_W = 9;

    localparam logic [1:0] ST_CLOSED = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/envelope_follower_if.sv
// Sample-in / level-out stream bundle of the envelope follower.
// master: sample source; slave: follower (drives level/level_valid/gate).
interface envelope_follower_if #(
    parameter int SAMPLE_BITS = envelope_follower_pkg::SAMPLE_BITS_DEF
);

    logic                   sample_valid;
    logic [SAMPLE_BITS-1:0] sample;
    logic [7:0]             level;
    logic                   level_valid;
    logic                   gate;

    modport master (
        output sample_valid, sample,
        input  level, level_valid, gate
    );

    modport slave (
        input  sample_valid, sample,
        output level, level_valid, gate
    );

endinterface

// File: rtl/envelope_follower_rate_stepper.sv
// rate_stepper: 8-bit rate accumulator; step pulses on carry-out.
// Ports: clk, rst_n, advance (update cycle), en (accumulate, else clear), rate, step.
module rate_stepper
    import envelope_follower_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             en,
    input  logic [ACC_W-2:0] rate,
    output logic             step
);

    logic [ACC_W-2:0] acc;
    logic [ACC_W-1:0] sum;

    assign sum  = {1'b0, acc} + {1'b0, rate};
    assign step = advance & en & sum[ACC_W-1];

    // Idle direction is cleared so a direction change starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (advance) begin
            acc <= en ? sum[ACC_W-2:0] : '0;
        end
    end

endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: rectifies PCM, tracks level with attack/release steppers,
// gates with hysteresis+hold. Ports: clk, rst_n, bus (slave), a, r, threshold, hysteresis.
module envelope_follower
    import envelope_follower_pkg::*;
#(
    parameter int SAMPLE_BITS  = SAMPLE_BITS_DEF,
    parameter int HOLD_SAMPLES = 1024,
    parameter int HOLD_BITS    = $clog2(HOLD_SAMPLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    envelope_follower_if.slave    bus,
    input  logic [7:0]            a,
    input  logic [7:0]            r,
    input  logic [7:0]            threshold,
    input  logic [7:0]            hysteresis
);

    logic [SAMPLE_BITS-1:0] neg;
    logic [SAMPLE_BITS-2:0] mag;
    logic [7:0]             target;

    logic                   s1_valid;
    logic [7:0]             s1_target;

    logic [7:0]             level;
    logic [7:0]             level_next;
    logic                   level_valid;
    logic                   gate;
    logic                   atk_step;
    logic                   rel_step;
    logic [7:0]             close_th;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [HOLD_BITS-1:0]   hold_cnt;
    logic [HOLD_BITS-1:0]   hold_next;

    // Stage 1: rectify; only the most-negative code overflows on negation
    assign neg = -bus.sample;

    always_comb begin
        mag = bus.sample[SAMPLE_BITS-2:0];
        if (bus.sample[SAMPLE_BITS-1]) begin
            if (neg[SAMPLE_BITS-1]) begin
                mag = '1;
            end else begin
                mag = neg[SAMPLE_BITS-2:0];
            end
        end
    end

    assign target = 8'(mag >> (SAMPLE_BITS - 9));

    // Stage 2: step towards target by at most one code per sample
    rate_stepper u_atk (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (s1_valid),
        .en      (s1_target > level),
        .rate    (a),
        .step    (atk_step)
    );

    rate_stepper u_rel (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (s1_valid),
        .en      (s1_target < level),
        .rate    (r),
        .step    (rel_step)
    );

    always_comb begin
        level_next = level;
        if (atk_step) begin
            level_next = level + 8'd1;
        end else if (rel_step) begin
            level_next = level - 8'd1;
        end
    end

    assign close_th = (threshold > hysteresis) ? threshold - hysteresis : 8'd0;

    // Gate FSM evaluated on the freshly updated level
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        unique case (state)
            ST_CLOSED: begin
                if (level_next >= threshold) begin
                    state_next = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (level_next < close_th) begin
                    state_next = ST_HOLD;
                    hold_next  = HOLD_BITS'(HOLD_SAMPLES - 1);
                end
            end
            ST_HOLD: begin
                if (level_next >= threshold) begin
                    state_next = ST_OPEN;
                end else if (hold_cnt == '0) begin
                    state_next = ST_CLOSED;
                end else begin
                    hold_next = hold_cnt - HOLD_BITS'(1);
                end
            end
            default: begin
                state_next = ST_CLOSED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_target   <= '0;
            level       <= '0;
            level_valid <= 1'b0;
            gate        <= 1'b0;
            state       <= ST_CLOSED;
            hold_cnt    <= '0;
        end else begin
            s1_valid    <= bus.sample_valid;
            s1_target   <= target;
            level_valid <= s1_valid;
            if (s1_valid) begin
                level    <= level_next;
                state    <= state_next;
                hold_cnt <= hold_next;
                gate     <= (state_next != ST_CLOSED);
            end
        end
    end

    assign bus.level       = level;
    assign bus.level_valid = level_valid;
    assign bus.gate        = gate;

endmodule

// File: tb/tb_envelope_follower.sv
// Bench for envelope_follower: directed scenarios plus random stream,
// every cycle compared against an integer model of the follower.
module tb_envelope_follower;

    localparam int HOLD = 16;
    localparam int M_CLOSED = 0;
    localparam int M_OPEN   = 1;
    localparam int M_HOLD   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, r, threshold, hysteresis;

    int checks = 0;
    int passed = 0;

    envelope_follower_if #(.SAMPLE_BITS(16)) bus ();

    envelope_follower #(
        .SAMPLE_BITS  (16),
        .HOLD_SAMPLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .a          (a),
        .r          (r),
        .threshold  (threshold),
        .hysteresis (hysteresis)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: target is |sample| (clipped to 32767) in units of 128
    function automatic int tgt_of(input logic [15:0] s);
        int v;
        int m;
        v = int'($signed(s));
        m = (v < 0) ? -v : v;
        if (m > 32767) m = 32767;
        return m / 128;
    endfunction

    int m_level, m_atk, m_rel, m_state, m_since;
    bit m_valid, m_gate, p_valid;
    int p_target;

    function automatic void model_step(input int tgt, output int lv, output int la,
                                       output int lr, output int st, output int since);
        int close;
        lv = m_level; la = m_atk; lr = m_rel; st = m_state; since = m_since;
        if (tgt > lv) begin
            lr = 0;
            la = la + int'(a);
            if (la >= 256) begin la -= 256; lv++; end
        end else if (tgt < lv) begin
            la = 0;
            lr = lr + int'(r);
            if (lr >= 256) begin lr -= 256; lv--; end
        end else begin
            la = 0; lr = 0;
        end
        close = int'(threshold) - int'(hysteresis);
        if (close < 0) close = 0;
        case (st)
            M_CLOSED: if (lv >= int'(threshold)) st = M_OPEN;
            M_OPEN: if (lv < close) begin st = M_HOLD; since = 0; end
            default: begin
                if (lv >= int'(threshold)) st = M_OPEN;
                else begin
                    since++;
                    if (since >= HOLD) st = M_CLOSED;
                end
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int nl, na, nr, ns, nsi;
        if (!rst_n) begin
            m_level <= 0; m_atk <= 0; m_rel <= 0; m_state <= M_CLOSED;
            m_since <= 0; m_valid <= 0; m_gate <= 0; p_valid <= 0; p_target <= 0;
        end else begin
            if (p_valid) begin
                model_step(p_target, nl, na, nr, ns, nsi);
                m_level <= nl; m_atk <= na; m_rel <= nr;
                m_state <= ns; m_since <= nsi;
                m_gate <= (ns != M_CLOSED);
            end
            m_valid  <= p_valid;
            p_valid  <= bus.sample_valid;
            p_target <= tgt_of(bus.sample);
        end
    end

    always @(negedge clk) begin
        check("level_valid", int'(bus.level_valid), int'(m_valid));
        check("level", int'(bus.level), m_level);
        check("gate", int'(bus.gate), int'(m_gate));
    end

    task automatic drive(input logic [15:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sample_valid = 1'b1;
            bus.sample = s;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Streams n samples, counting level_valid cycles that are in hold
    // (gate high, level below lo) and cycles where the gate is closed
    task automatic run_count(input logic [15:0] s, input int n, input int lo,
                             output int nhold, output int nclosed);
        nhold = 0;
        nclosed = 0;
        for (int i = 0; i < n + 4; i++) begin
            @(negedge clk);
            if (bus.level_valid) begin
                if (bus.gate && int'(bus.level) < lo) nhold++;
                if (!bus.gate) nclosed++;
            end
            bus.sample_valid = (i < n);
            bus.sample = s;
        end
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        int nh, nc, nh2, nc2;
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample = '0;
        a = 8'd128; r = 8'd0; threshold = 8'd255; hysteresis = 8'd0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.sample_valid = ~bus.sample_valid;
            bus.sample = 16'h7fff;
        end
        check("rst_level", int'(bus.level), 0);
        check("rst_gate", int'(bus.gate), 0);
        check("rst_level_valid", int'(bus.level_valid), 0);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample = 16'h0000;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check("latency_1clk", int'(bus.level_valid), 0);
        @(negedge clk);
        check("latency_2clk", int'(bus.level_valid), 1);
        @(negedge clk);
        check("latency_3clk", int'(bus.level_valid), 0);

        drive(16'h4000, 256);
        check("attack_128", int'(bus.level), 128);
        drive(16'h4000, 40);
        check("attack_hold_128", int'(bus.level), 128);

        a = 8'd255;
        drive(16'h8000, 400);
        check("sat_255", int'(bus.level), 255);
        check("sat_gate_open", int'(bus.gate), 1);
        r = 8'd0;
        drive(16'h0000, 100);
        check("r0_hold_255", int'(bus.level), 255);
        r = 8'd255;
        drive(16'h0000, 400);
        check("decay_0", int'(bus.level), 0);
        check("decay_gate_closed", int'(bus.gate), 0);

        threshold = 8'd100;
        hysteresis = 8'd20;
        drive(16'd14080, 200);
        check("gate_level_110", int'(bus.level), 110);
        check("gate_open", int'(bus.gate), 1);
        drive(16'd11520, 100);
        check("gate_level_90", int'(bus.level), 90);
        check("gate_band_open", int'(bus.gate), 1);
        run_count(16'h0000, 150, 80, nh, nc);
        check("hold_len", nh, HOLD);
        check("hold_final_gate", int'(bus.gate), 0);

        hysteresis = 8'd5;
        drive(16'd14080, 200);
        check("retrig_open", int'(bus.gate), 1);
        run_count(16'h0000, 18, 95, nh, nc);
        run_count(16'd14080, 60, 95, nh2, nc2);
        check("retrig_in_hold", (nh > 0) ? 1 : 0, 1);
        check("retrig_no_close", nc + nc2, 0);
        run_count(16'h0000, 150, 95, nh, nc);
        check("retrig_fresh_hold", nh, HOLD);

        drive(16'd25600, 300);
        check("pre_rst_level", int'(bus.level), 200);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample = 16'd25600;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_level", int'(bus.level), 0);
        check("async_rst_gate", int'(bus.gate), 0);
        check("async_rst_lv", int'(bus.level_valid), 0);
        repeat (3) @(negedge clk);
        bus.sample_valid = 1'b0;
        rst_n = 1'b1;
        nc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.level_valid) nc++;
        end
        check("no_stray_lv", nc, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 50 == 0) begin
                a = 8'($urandom_range(0, 255));
                r = 8'($urandom_range(0, 255));
                threshold = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                hysteresis = 8'($urandom_range(0, 255));
            end
            bus.sample_valid = ($urandom_range(0, 3) != 0);
            bus.sample = 16'($urandom);
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
